user_obi_dma: RTL and testbench

Single-channel word-copy engine in the user domain. It is the OBI manager behind `user_mgr_obi_req_o`. Software programs source, destination and length through an OBI subordinate port. The engine then copies words from an incrementing source address (SRAM, font ROM) to a fixed or incrementing destination, typically the `obi_spi_peripheral` data register, so display traffic runs without CPU involvement.

---
 rtl/user_pkg.sv | 58 +++++
 rtl/user_obi_dma_regs.sv | 91 +++++++++
 rtl/user_obi_dma.sv | 158 +++++++++++++++
 tb/tb_user_obi_dma.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain peripherals: OBI channel structs,
// the DMA register map and copy-FSM states, and the DMA slot in the user demux.
package user_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } obi_rsp_t;

    typedef obi_req_t sbr_obi_req_t;
    typedef obi_rsp_t sbr_obi_rsp_t;
    typedef obi_req_t mgr_obi_req_t;
    typedef obi_rsp_t mgr_obi_rsp_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam logic [31:0]    UserDma     = 32'd3;
    localparam addr_map_rule_t UserDmaRule = '{
        idx:        UserDma,
        start_addr: 32'h2000_3000,
        end_addr:   32'h2000_3010
    };

    localparam logic [3:0] DmaSrcOffset  = 4'h0;
    localparam logic [3:0] DmaDstOffset  = 4'h4;
    localparam logic [3:0] DmaLenOffset  = 4'h8;
    localparam logic [3:0] DmaCtrlOffset = 4'hC;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } dma_state_e;

    // Byte offset of the addressed DMA register; only word index bits matter.
    function automatic logic [3:0] dma_reg_offset(input logic [31:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/user_obi_dma_regs.sv
// Configuration register file of the word-copy DMA. Writes are dropped while the
// engine is busy; status bits come in from the copy FSM.
module user_obi_dma_regs
    import user_pkg::*;
#(
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  sbr_obi_req_t        obi_sbr_req,
    output sbr_obi_rsp_t        obi_sbr_rsp,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LenWidth-1:0] len,
    output logic                dst_inc,
    output logic                start,
    input  logic                busy,
    input  logic                done,
    input  logic                err
);

    logic [31:0]         src_r;
    logic [31:0]         dst_r;
    logic [31:0]         rdata_r;
    logic [31:0]         rdata_s;
    logic [LenWidth-1:0] len_r;
    logic                dst_inc_r;
    logic                rvalid_r;
    logic                rid_r;
    logic                wr_s;
    logic [3:0]          off_s;
    logic                unused_s;

    assign off_s    = dma_reg_offset(obi_sbr_req.addr);
    assign wr_s     = obi_sbr_req.req & obi_sbr_req.we & ~busy;
    assign start    = wr_s & (off_s == DmaCtrlOffset) & obi_sbr_req.wdata[0];
    assign src      = src_r;
    assign dst      = dst_r;
    assign len      = len_r;
    assign dst_inc  = dst_inc_r;
    assign unused_s = ^{obi_sbr_req.be, obi_sbr_req.addr[31:4], obi_sbr_req.addr[1:0]};

    // Read-data selection over the register map
    always_comb begin
        rdata_s = 32'h0;
        case (off_s)
            DmaSrcOffset:  rdata_s = src_r;
            DmaDstOffset:  rdata_s = dst_r;
            DmaLenOffset:  rdata_s[LenWidth-1:0] = len_r;
            DmaCtrlOffset: rdata_s = {28'h0, dst_inc_r, err, done, busy};
            default:       rdata_s = 32'h0;
        endcase
    end

    // Register writes and the single-cycle subordinate response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r     <= 32'h0;
            dst_r     <= 32'h0;
            len_r     <= '0;
            dst_inc_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= 1'b0;
            rdata_r   <= 32'h0;
        end else begin
            rvalid_r <= obi_sbr_req.req;
            rid_r    <= obi_sbr_req.aid;
            rdata_r  <= (obi_sbr_req.req & ~obi_sbr_req.we) ? rdata_s : 32'h0;
            if (wr_s) begin
                case (off_s)
                    DmaSrcOffset:  src_r     <= obi_sbr_req.wdata;
                    DmaDstOffset:  dst_r     <= obi_sbr_req.wdata;
                    DmaLenOffset:  len_r     <= obi_sbr_req.wdata[LenWidth-1:0];
                    DmaCtrlOffset: dst_inc_r <= obi_sbr_req.wdata[1];
                    default:       ;
                endcase
            end
        end
    end

    // Response channel: always granted, never errors
    always_comb begin
        obi_sbr_rsp        = '0;
        obi_sbr_rsp.gnt    = 1'b1;
        obi_sbr_rsp.rvalid = rvalid_r;
        obi_sbr_rsp.rdata  = rdata_r;
        obi_sbr_rsp.rid    = rid_r;
        obi_sbr_rsp.err    = 1'b0;
    end

endmodule

// File: rtl/user_obi_dma.sv
// Single-channel word-copy engine: reads from an incrementing source and writes to a
// fixed or incrementing destination, one outstanding OBI transaction at a time.
module user_obi_dma
    import user_pkg::*;
#(
    parameter int unsigned LenWidth = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t obi_sbr_req_i,
    output sbr_obi_rsp_t obi_sbr_rsp_o,
    output mgr_obi_req_t obi_mgr_req_o,
    input  mgr_obi_rsp_t obi_mgr_rsp_i,
    output logic         irq_o
);

    localparam logic [LenWidth-1:0] LenOne = LenWidth'(32'd1);

    dma_state_e          state_r;
    logic [31:0]         src_r;
    logic [31:0]         dst_r;
    logic [LenWidth-1:0] cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                irq_r;
    mgr_obi_req_t        mgr_req_r;
    logic [31:0]         cfg_src_s;
    logic [31:0]         cfg_dst_s;
    logic [LenWidth-1:0] cfg_len_s;
    logic                dst_inc_s;
    logic                start_s;
    logic                unused_s;

    user_obi_dma_regs #(
        .LenWidth (LenWidth)
    ) u_regs (
        .clk         (clk_i),
        .rst         (rst_i),
        .obi_sbr_req (obi_sbr_req_i),
        .obi_sbr_rsp (obi_sbr_rsp_o),
        .src         (cfg_src_s),
        .dst         (cfg_dst_s),
        .len         (cfg_len_s),
        .dst_inc     (dst_inc_s),
        .start       (start_s),
        .busy        (busy_r),
        .done        (done_r),
        .err         (err_r)
    );

    assign obi_mgr_req_o = mgr_req_r;
    assign irq_o         = irq_r;
    assign unused_s      = obi_mgr_rsp_i.rid;

    // Copy sequencer: working copies, sticky status, interrupt pulse and manager request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            src_r     <= 32'h0;
            dst_r     <= 32'h0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            irq_r     <= 1'b0;
            mgr_req_r <= '0;
        end else begin
            irq_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        done_r <= 1'b0;
                        err_r  <= 1'b0;
                        if (cfg_len_s == '0) begin
                            done_r <= 1'b1;
                            irq_r  <= 1'b1;
                        end else begin
                            src_r          <= cfg_src_s;
                            dst_r          <= cfg_dst_s;
                            cnt_r          <= cfg_len_s;
                            busy_r         <= 1'b1;
                            state_r        <= RD_REQ;
                            mgr_req_r.req  <= 1'b1;
                            mgr_req_r.we   <= 1'b0;
                            mgr_req_r.addr <= cfg_src_s;
                            mgr_req_r.be   <= 4'hF;
                        end
                    end
                end
                RD_REQ: begin
                    if (obi_mgr_rsp_i.gnt) begin
                        mgr_req_r.req <= 1'b0;
                        state_r       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (obi_mgr_rsp_i.rvalid) begin
                        if (obi_mgr_rsp_i.err) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            err_r   <= 1'b1;
                            irq_r   <= 1'b1;
                        end else begin
                            // wdata doubles as the data buffer between read and write
                            mgr_req_r.req   <= 1'b1;
                            mgr_req_r.we    <= 1'b1;
                            mgr_req_r.addr  <= dst_r;
                            mgr_req_r.wdata <= obi_mgr_rsp_i.rdata;
                            mgr_req_r.be    <= 4'hF;
                            state_r         <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (obi_mgr_rsp_i.gnt) begin
                        mgr_req_r.req <= 1'b0;
                        state_r       <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (obi_mgr_rsp_i.rvalid) begin
                        if (obi_mgr_rsp_i.err) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            err_r   <= 1'b1;
                            irq_r   <= 1'b1;
                        end else begin
                            src_r <= src_r + 32'd4;
                            if (dst_inc_s) begin
                                dst_r <= dst_r + 32'd4;
                            end
                            cnt_r <= cnt_r - LenOne;
                            if (cnt_r == LenOne) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                irq_r   <= 1'b1;
                            end else begin
                                state_r        <= RD_REQ;
                                mgr_req_r.req  <= 1'b1;
                                mgr_req_r.we   <= 1'b0;
                                mgr_req_r.addr <= src_r + 32'd4;
                                mgr_req_r.be   <= 4'hF;
                            end
                        end
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    mgr_req_r.req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_obi_dma.sv
// Directed bench for user_obi_dma: a CPU-side driver on the config port and a memory
// model on the manager port with grant stalls and read-error injection.
module tb_user_obi_dma;
    import user_pkg::*;

    localparam logic [31:0] RegBase = 32'h2000_3000;
    localparam logic [31:0] SpiData = 32'h3000_0008;

    logic         clk;
    logic         rst;
    logic         irq;
    sbr_obi_req_t sreq;
    sbr_obi_rsp_t srsp;
    mgr_obi_req_t mreq;
    mgr_obi_rsp_t mrsp;
    logic         mgnt;
    logic         m_rvalid;
    logic         m_err;
    logic [31:0]  m_rdata;

    int n_checks;
    int n_fail;
    int rd_total;
    int wr_total;
    int stall_total;
    int stall_target;
    int err_rd_at;
    int irq_total;
    int unstable_cnt;

    logic        hold_v = 1'b0;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    logic [31:0] mem[logic [31:0]];

    user_obi_dma #(
        .LenWidth (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .obi_sbr_req_i (sreq),
        .obi_sbr_rsp_o (srsp),
        .obi_mgr_req_o (mreq),
        .obi_mgr_rsp_i (mrsp),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    assign mgnt = mreq.req && !(mreq.we && (stall_total < stall_target));

    always_comb begin
        mrsp        = '0;
        mrsp.gnt    = mgnt;
        mrsp.rvalid = m_rvalid;
        mrsp.rdata  = m_rdata;
        mrsp.err    = m_err;
    end

    // Memory model on the manager port: logs transactions, injects stalls and errors
    always @(posedge clk) begin
        if (rst) begin
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_rvalid <= mreq.req && mgnt;
            m_err    <= 1'b0;
            if (mreq.req && mgnt) begin
                log_addr.push_back(mreq.addr);
                log_we.push_back(mreq.we);
                log_wdata.push_back(mreq.wdata);
                if (!mreq.we) begin
                    rd_total <= rd_total + 1;
                    m_rdata  <= mem_rd(mreq.addr);
                    m_err    <= (rd_total + 1 == err_rd_at);
                end else begin
                    wr_total <= wr_total + 1;
                end
            end
            if (mreq.req && mreq.we && !mgnt) stall_total <= stall_total + 1;
        end
        if (hold_v && (!mreq.req || mreq.addr !== hold_addr || mreq.we !== hold_we ||
                       mreq.wdata !== hold_wdata))
            unstable_cnt <= unstable_cnt + 1;
        hold_v     <= mreq.req && !mgnt;
        hold_addr  <= mreq.addr;
        hold_we    <= mreq.we;
        hold_wdata <= mreq.wdata;
    end

    // Interrupt pulse counter
    always @(negedge clk) begin
        if (irq === 1'b1) irq_total <= irq_total + 1;
    end

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        sreq.req   = 1'b1;
        sreq.we    = 1'b1;
        sreq.addr  = addr;
        sreq.wdata = data;
        sreq.be    = 4'hF;
        @(negedge clk);
        sreq.req = 1'b0;
        sreq.we  = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        sreq.req  = 1'b1;
        sreq.we   = 1'b0;
        sreq.addr = addr;
        @(negedge clk);
        sreq.req = 1'b0;
        data     = srsp.rdata;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (irq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        n_checks++;
        if (mreq !== '0) begin
            n_fail++;
            $display("FAIL reset_mgr_req: got %h expected 0", mreq);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(RegBase + 32'(4 * i), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", i, rd);
            end
        end
    endtask

    task automatic test_basic_copy();
        int          base;
        int          irq_base;
        int          n;
        logic [31:0] rd;
        logic [31:0] exp_d[3];
        logic [31:0] exp_a;
        logic        exp_we;
        exp_d = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) mem[32'h1000_0000 + 32'(4 * i)] = exp_d[i];
        cpu_write(RegBase + 32'h0, 32'h1000_0000);
        cpu_write(RegBase + 32'h4, SpiData);
        cpu_write(RegBase + 32'h8, 32'd3);
        base     = log_addr.size();
        irq_base = irq_total;
        cpu_write(RegBase + 32'hC, 32'h1);
        wait_irq(n);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n !== 12) begin
            n_fail++;
            $display("FAIL basic_cycles: got %0d expected 12", n);
        end
        n_checks++;
        if (log_addr.size() - base !== 6) begin
            n_fail++;
            $display("FAIL basic_txn_count: got %0d expected 6", log_addr.size() - base);
        end
        for (int i = 0; i < 6 && base + i < log_addr.size(); i++) begin
            exp_we = (i % 2 == 1);
            exp_a  = exp_we ? SpiData : 32'h1000_0000 + 32'(4 * (i / 2));
            n_checks++;
            if (log_we[base+i] !== exp_we || log_addr[base+i] !== exp_a ||
                (exp_we && log_wdata[base+i] !== exp_d[i/2])) begin
                n_fail++;
                $display("FAIL basic_txn%0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h",
                         i, log_we[base+i], log_addr[base+i], log_wdata[base+i], exp_we, exp_a);
            end
        end
        n_checks++;
        if (irq_total - irq_base !== 1) begin
            n_fail++;
            $display("FAIL basic_irq_count: got %0d expected 1", irq_total - irq_base);
        end
        cpu_read(RegBase + 32'hC, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL basic_ctrl: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_len_zero();
        int          base;
        int          irq_base;
        logic [31:0] rd;
        cpu_write(RegBase + 32'h8, 32'd0);
        base     = log_addr.size();
        irq_base = irq_total;
        cpu_write(RegBase + 32'hC, 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_irq_next_cycle: got %b expected 1", irq);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (log_addr.size() !== base) begin
            n_fail++;
            $display("FAIL len0_no_traffic: got %0d txns expected 0", log_addr.size() - base);
        end
        n_checks++;
        if (irq_total - irq_base !== 1) begin
            n_fail++;
            $display("FAIL len0_irq_count: got %0d expected 1", irq_total - irq_base);
        end
        cpu_read(RegBase + 32'hC, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL len0_ctrl: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_read_error();
        int          rd_base;
        int          wr_base;
        int          irq_base;
        int          n;
        logic [31:0] rd;
        cpu_write(RegBase + 32'h0, 32'h1000_0100);
        cpu_write(RegBase + 32'h4, SpiData);
        cpu_write(RegBase + 32'h8, 32'd4);
        rd_base   = rd_total;
        wr_base   = wr_total;
        irq_base  = irq_total;
        err_rd_at = rd_total + 2;
        cpu_write(RegBase + 32'hC, 32'h3);
        wait_irq(n);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL rderr_timeout: got %0d cycles expected < 200", n);
        end
        n_checks++;
        if (wr_total - wr_base !== 1) begin
            n_fail++;
            $display("FAIL rderr_writes: got %0d expected 1", wr_total - wr_base);
        end
        n_checks++;
        if (rd_total - rd_base !== 2) begin
            n_fail++;
            $display("FAIL rderr_reads: got %0d expected 2", rd_total - rd_base);
        end
        n_checks++;
        if (irq_total - irq_base !== 1) begin
            n_fail++;
            $display("FAIL rderr_irq_count: got %0d expected 1", irq_total - irq_base);
        end
        cpu_read(RegBase + 32'hC, rd);
        n_checks++;
        if (rd !== 32'hC) begin
            n_fail++;
            $display("FAIL rderr_ctrl: got %h expected 0000000c", rd);
        end
    endtask

    task automatic test_gnt_stall();
        int rd_base;
        int wr_base;
        int st_base;
        int un_base;
        int base;
        int n;
        mem[32'h1000_0200] = 32'hCAFE_0001;
        mem[32'h1000_0204] = 32'hCAFE_0002;
        cpu_write(RegBase + 32'h0, 32'h1000_0200);
        cpu_write(RegBase + 32'h4, SpiData);
        cpu_write(RegBase + 32'h8, 32'd2);
        rd_base      = rd_total;
        wr_base      = wr_total;
        st_base      = stall_total;
        un_base      = unstable_cnt;
        base         = log_addr.size();
        stall_target = stall_total + 5;
        cpu_write(RegBase + 32'hC, 32'h1);
        wait_irq(n);
        repeat (3) @(negedge clk);
        n_checks++;
        if (stall_total - st_base !== 5) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d expected 5", stall_total - st_base);
        end
        n_checks++;
        if (unstable_cnt - un_base !== 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d changes expected 0", unstable_cnt - un_base);
        end
        n_checks++;
        if (wr_total - wr_base !== 2 || rd_total - rd_base !== 2) begin
            n_fail++;
            $display("FAIL stall_txn_count: got rd=%0d wr=%0d expected rd=2 wr=2",
                     rd_total - rd_base, wr_total - wr_base);
        end
        n_checks++;
        if (log_addr.size() < base + 2 || log_wdata[base+1] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL stall_wdata: got %h expected cafe0001",
                     (log_addr.size() < base + 2) ? 32'h0 : log_wdata[base+1]);
        end
    endtask

    task automatic test_busy_ignore();
        int          base;
        int          irq_base;
        int          n;
        logic [31:0] rd;
        logic [31:0] exp_a;
        cpu_write(RegBase + 32'h0, 32'h1000_0300);
        cpu_write(RegBase + 32'h4, 32'h3000_0100);
        cpu_write(RegBase + 32'h8, 32'd3);
        base     = log_addr.size();
        irq_base = irq_total;
        cpu_write(RegBase + 32'hC, 32'h3);
        cpu_write(RegBase + 32'h0, 32'hDEAD_BEEC);
        cpu_write(RegBase + 32'hC, 32'h1);
        cpu_read(RegBase + 32'hC, rd);
        n_checks++;
        if (rd !== 32'h9) begin
            n_fail++;
            $display("FAIL busy_ctrl_during: got %h expected 00000009", rd);
        end
        wait_irq(n);
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() - base !== 6) begin
            n_fail++;
            $display("FAIL busy_txn_count: got %0d expected 6", log_addr.size() - base);
        end
        for (int i = 0; i < 6 && base + i < log_addr.size(); i++) begin
            exp_a = (i % 2 == 1) ? 32'h3000_0100 + 32'(4 * (i / 2)) : 32'h1000_0300 + 32'(4 * (i / 2));
            n_checks++;
            if (log_addr[base+i] !== exp_a) begin
                n_fail++;
                $display("FAIL busy_addr%0d: got %h expected %h", i, log_addr[base+i], exp_a);
            end
        end
        n_checks++;
        if (irq_total - irq_base !== 1) begin
            n_fail++;
            $display("FAIL busy_irq_count: got %0d expected 1", irq_total - irq_base);
        end
        cpu_read(RegBase + 32'h0, rd);
        n_checks++;
        if (rd !== 32'h1000_0300) begin
            n_fail++;
            $display("FAIL busy_src_kept: got %h expected 10000300", rd);
        end
        cpu_read(RegBase + 32'hC, rd);
        n_checks++;
        if (rd !== 32'hA) begin
            n_fail++;
            $display("FAIL busy_ctrl_after: got %h expected 0000000a", rd);
        end
    endtask

    task automatic test_wrap_and_reset();
        int          base;
        int          rd_base;
        int          irq_base;
        int          n;
        logic [31:0] rd;
        cpu_write(RegBase + 32'h0, 32'hFFFF_FFFC);
        cpu_write(RegBase + 32'h4, 32'h3000_0000);
        cpu_write(RegBase + 32'h8, 32'd2);
        base    = log_addr.size();
        rd_base = rd_total;
        cpu_write(RegBase + 32'hC, 32'h3);
        n = 0;
        while (!(rd_total - rd_base == 2 && mreq.req === 1'b1 && mreq.we === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d cycles expected < 100", n);
        end
        n_checks++;
        if (log_addr.size() < base + 3 || log_addr[base] !== 32'hFFFF_FFFC || log_addr[base+2] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_read_addrs: got %0d txns, first %h expected fffffffc then 00000000",
                     log_addr.size() - base, (log_addr.size() > base) ? log_addr[base] : 32'h0);
        end
        n_checks++;
        if (mreq.addr !== 32'h3000_0004) begin
            n_fail++;
            $display("FAIL wrap_dst_inc: got %h expected 30000004", mreq.addr);
        end
        irq_base = irq_total;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mreq.req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_drop: got %b expected 0", mreq.req);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_read(RegBase + 32'(4 * i), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_reg%0d: got %h expected 00000000", i, rd);
            end
        end
        n_checks++;
        if (irq_total - irq_base !== 0 || mreq.req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet: got irq=%0d req=%b expected 0 and 0",
                     irq_total - irq_base, mreq.req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        sreq         = '0;
        stall_target = 0;
        err_rd_at    = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_read_error();
        test_gnt_stall();
        test_busy_ignore();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
